// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, thresholds, flush and error pulses
module sync_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_ok, rd_ok;
  // flags come from the registered count only, never from the request inputs
  always_comb begin
    full = count == FULL_CNT;
    empty = count == '0;
    almost_full = count >= AF_CNT;
    almost_empty = count <= AE_CNT;
    wr_ok = wr_en & (!full | rd_en);
    rd_ok = rd_en & !empty;
  end
  always_ff @(posedge clk)
    if (reset_n && !clr && wr_ok) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      dout_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) begin
        rp <= rp + AW'(1);
        dout <= mem[rp];
      end
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      dout_valid <= rd_ok;
      overflow <= wr_en & !wr_ok;
      underflow <= rd_en & !rd_ok;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1
module tb_sync_fifo_param;
  logic clk = 0, reset_n = 0, clr = 0, wr_en = 0, rd_en = 0;
  logic [7:0] din = 0, dout;
  logic dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  int compared = 0, mismatched = 0;

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; din = d; rd_en = r; clr = c;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; clr = 0;
  endtask

  task automatic st(input string tag, input int cnt, input logic dv, input logic ov, input logic uf);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".dv"}, 32'(dout_valid), 32'(dv));
    chk({tag, ".ov"}, 32'(overflow), 32'(ov));
    chk({tag, ".uf"}, 32'(underflow), 32'(uf));
  endtask

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'hA1; fill[1] = 8'hB2; fill[2] = 8'hC3; fill[3] = 8'hD4;
    // reset and idle
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    st("rst", 0, 0, 0, 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.ae", 32'(almost_empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.af", 32'(almost_full), 0);
    chk("rst.dout", 32'(dout), 0);
    // fill and overflow
    for (int i = 0; i < 4; i++) begin
      cyc(1, fill[i], 0, 0);
      st("fill", i + 1, 0, 0, 0);
      chk("fill.af", 32'(almost_full), 32'(i >= 2));
      chk("fill.full", 32'(full), 32'(i == 3));
      chk("fill.ae", 32'(almost_empty), 32'(i == 0));
    end
    cyc(1, 8'hE5, 0, 0);
    st("ovf", 4, 0, 1, 0);
    cyc(0, 0, 0, 0);
    st("ovf.pulse", 4, 0, 0, 0);
    // drain and underflow
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      st("drain", 3 - i, 1, 0, 0);
      chk("drain.dout", 32'(dout), 32'(fill[i]));
    end
    chk("drain.empty", 32'(empty), 1);
    cyc(0, 0, 1, 0);
    st("udf", 0, 0, 0, 1);
    chk("udf.dout", 32'(dout), 32'hD4);
    chk("udf.empty", 32'(empty), 1);
    cyc(0, 0, 0, 0);
    st("udf.pulse", 0, 0, 0, 0);
    // wrap with concurrent read/write
    for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 0, 0);
    chk("wrap.cnt3", 32'(count), 3);
    for (int i = 1; i <= 2; i++) begin
      cyc(0, 0, 1, 0);
      chk("wrap.rd", 32'(dout), 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1, 8'h10 + 8'(i), 1, 0);
      st("conc", 1, 1, 0, 0);
      chk("conc.dout", 32'(dout), i == 0 ? 32'h03 : 32'h10 + 32'(i - 1));
    end
    // full with simultaneous read/write
    for (int i = 0; i < 3; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
    chk("bnd.full", 32'(full), 1);
    cyc(1, 8'h23, 1, 0);
    st("bnd.fullrw", 4, 1, 0, 0);
    chk("bnd.fullrw.dout", 32'(dout), 32'h15);
    chk("bnd.fullrw.full", 32'(full), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      chk("bnd.drain", 32'(dout), 32'h20 + 32'(i));
    end
    chk("bnd.empty", 32'(empty), 1);
    // empty with simultaneous read/write: no fall-through
    cyc(1, 8'h30, 1, 0);
    st("bnd.emptyrw", 1, 0, 0, 1);
    chk("bnd.emptyrw.dout", 32'(dout), 32'h23);
    cyc(0, 0, 1, 0);
    st("bnd.after", 0, 1, 0, 0);
    chk("bnd.after.dout", 32'(dout), 32'h30);
    // flush wins over write
    for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
    chk("clr.pre", 32'(count), 3);
    cyc(1, 8'h43, 0, 1);
    st("clr", 0, 0, 0, 0);
    chk("clr.empty", 32'(empty), 1);
    chk("clr.dout", 32'(dout), 32'h30);
    cyc(0, 0, 1, 0);
    st("clr.dropped", 0, 0, 0, 1);
    // asynchronous reset between edges
    cyc(1, 8'h50, 0, 0);
    cyc(1, 8'h51, 0, 0);
    cyc(0, 0, 1, 0);
    st("ar.pre", 1, 1, 0, 0);
    chk("ar.pre.dout", 32'(dout), 32'h50);
    #2 reset_n = 0;
    #1;
    st("ar", 0, 0, 0, 0);
    chk("ar.dout", 32'(dout), 0);
    chk("ar.empty", 32'(empty), 1);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    cyc(1, 8'h60, 0, 0);
    cyc(0, 0, 1, 0);
    st("ar.post", 0, 1, 0, 0);
    chk("ar.post.dout", 32'(dout), 32'h60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
